// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready byte FIFO; runtime-configurable 5-8 data bits,
// none/even/odd parity and 1 or 2 stop bits, with back-to-back frames and no idle gap.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CPB_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CPB_W-1:0]              cfg_cpb,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, fifo_nonempty;
  logic [CPB_W-1:0] cpb_q, bit_cnt;
  logic [7:0]       data_q, data_mask;
  logic [2:0]       last_idx_q, bit_idx;
  logic             par_en_q, par_odd_q, stop2_q;
  logic             period_end, frame_end, parity_bit;

  assign s_ready       = fifo_count < DEPTH_C;
  assign push          = s_valid && s_ready;
  assign fifo_nonempty = fifo_count != '0;
  assign period_end    = bit_cnt == cpb_q;
  // bit_idx counts stop periods; the frame ends on the period matching the stop count
  assign frame_end     = (state == STOP) && period_end && (bit_idx[0] == stop2_q);
  assign pop           = fifo_nonempty && ((state == IDLE) || frame_end);
  assign tx_done       = frame_end;
  assign tx_busy       = state != IDLE;

  always_comb begin
    data_mask  = 8'hFF >> (3'd7 - last_idx_q);
    parity_bit = (^(data_q & data_mask)) ^ par_odd_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_serial  <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      cpb_q      <= '0;
      data_q     <= '0;
      last_idx_q <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      if (state != IDLE) bit_cnt <= period_end ? '0 : bit_cnt + CPB_W'(1);
      // A pop from IDLE or at frame end loads the next frame straight into START
      if (pop) begin
        state      <= START;
        tx_serial  <= 1'b0;
        bit_cnt    <= '0;
        data_q     <= mem[rd_ptr];
        cpb_q      <= cfg_cpb;
        last_idx_q <= {1'b0, cfg_data_bits} + 3'd4;
        par_en_q   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        par_odd_q  <= cfg_parity == 2'b10;
        stop2_q    <= cfg_stop2;
      end else if (period_end) begin
        case (state)
          IDLE: ;
          START: begin
            state     <= DATA;
            bit_idx   <= '0;
            tx_serial <= data_q[0];
          end
          DATA: begin
            if (bit_idx == last_idx_q) begin
              bit_idx <= '0;
              if (par_en_q) begin
                state     <= PARITY;
                tx_serial <= parity_bit;
              end else begin
                state     <= STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= data_q[bit_idx + 3'd1];
            end
          end
          PARITY: begin
            state     <= STOP;
            tx_serial <= 1'b1;
          end
          STOP: begin
            if (frame_end) begin
              state     <= IDLE;
              tx_serial <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: line patterns per frame are hand-written strings, LSB first.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_cpb;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo #(.FIFO_DEPTH(4), .CPB_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_cpb(cfg_cpb), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int cpb, input int db, input int par, input int s2);
    cfg_cpb       = 16'(cpb);
    cfg_data_bits = 2'(db);
    cfg_parity    = 2'(par);
    cfg_stop2     = 1'(s2);
  endtask

  // Push one byte in cycle T; returns at mid-cycle T+1
  task automatic push_one(input string tag, input logic [7:0] b);
    @(posedge clk); #1 s_valid = 1'b1; s_data = b;
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    check({tag, "_cnt1"}, fifo_count, 1);
    check({tag, "_idle_line"}, tx_serial, 1);
  endtask

  // Next negedge must be the first cycle of the start bit
  task automatic frame(input string tag, input string pat, input int cpb);
    for (int b = 0; b < pat.len(); b++) begin
      for (int c = 0; c <= cpb; c++) begin
        @(negedge clk);
        check({tag, "_line"}, tx_serial, (pat[b] == 8'h31) ? 1 : 0);
        check({tag, "_busy"}, tx_busy, 1);
        check({tag, "_done"}, tx_done, (b == pat.len() - 1 && c == cpb) ? 1 : 0);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, tx_busy, 0);
    check({tag, "_line"}, tx_serial, 1);
    check({tag, "_cnt"}, fifo_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_low;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    set_cfg(3, 3, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_line", tx_serial, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", s_ready, 1);
    check("rst_cnt", fifo_count, 0);

    // 8N1, cpb=3, 0xA5
    push_one("t8n1", 8'hA5);
    check("t8n1_busy_T1", tx_busy, 0);
    frame("t8n1", "0101001011", 3);
    check_idle("t8n1_end");

    // parity, cpb=1
    set_cfg(1, 3, 1, 0);
    push_one("peven", 8'hA5);
    frame("peven", "01010010101", 1);
    set_cfg(1, 3, 2, 0);
    push_one("podd", 8'hA5);
    frame("podd", "01010010111", 1);
    check_idle("par_end");

    // 7E2, cpb=0, 0xC1
    set_cfg(0, 2, 1, 1);
    push_one("t7e2", 8'hC1);
    frame("t7e2", "01000001011", 0);
    check_idle("t7e2_end");

    // FIFO fill and back-to-back
    set_cfg(2, 3, 0, 0);
    @(posedge clk); #1;
    fork
      begin
        int w;
        for (int i = 1; i <= 5; i++) begin
          w = 0;
          s_valid = 1'b1; s_data = 8'(i);
          @(negedge clk);
          while (!s_ready && w < 100) begin
            w++;
            @(negedge clk);
          end
          check("fill_handshake", s_ready, 1);
          @(posedge clk); #1;
        end
        s_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        check("fill_cnt_T4", fifo_count, 3);
        check("fill_ready_T4", s_ready, 1);
        @(negedge clk);
        check("fill_cnt_T5", fifo_count, 4);
        check("fill_ready_T5", s_ready, 0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        check("fill_cnt_T1", fifo_count, 1);
        frame("fill1", "0100000001", 2);
        frame("fill2", "0010000001", 2);
        frame("fill3", "0110000001", 2);
        frame("fill4", "0001000001", 2);
        frame("fill5", "0101000001", 2);
      end
    join
    check_idle("fill_end");

    // config change mid-frame: 8N1 -> 5O1
    set_cfg(1, 3, 0, 0);
    @(posedge clk); #1 s_valid = 1'b1; s_data = 8'h3C;
    @(posedge clk); #1 s_data = 8'hF5;
    @(negedge clk);
    check("cfgchg_cnt_T1", fifo_count, 1);
    @(posedge clk); #1 s_valid = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 set_cfg(1, 0, 2, 0);
      end
    join_none
    frame("cfgchg_f1", "0001111001", 1);
    frame("cfgchg_f2", "01010101", 1);
    check_idle("cfgchg_end");

    // reset mid-frame with two bytes queued
    set_cfg(3, 3, 0, 0);
    @(posedge clk); #1 s_valid = 1'b1; s_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid_cnt_before", fifo_count, 2);
    check("rstmid_line_before", tx_serial, 0);
    check("rstmid_busy_before", tx_busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_line", tx_serial, 1);
    check("rstmid_busy", tx_busy, 0);
    check("rstmid_cnt", fifo_count, 0);
    check("rstmid_ready", s_ready, 1);
    n_done = 0;
    n_low  = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_done) n_done++;
      if (!tx_serial) n_low++;
    end
    check("rstmid_no_done", n_done, 0);
    check("rstmid_line_stays_high", n_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
